uart_tx_feeder: RTL and testbench

- Byte buffer and handshake sequencer directly upstream of uart_tx in the I2C-to-UART bridge.
- Accepts bytes from the I2C receive side into a synchronous FIFO.
- Drains the FIFO one byte at a time into uart_tx via its i_Tx_DV / i_Tx_Byte / o_Tx_Active / o_Tx_Done handshake.
- Never issues a new byte while a transmission is in flight.

---
 rtl/uart_tx_feeder.sv | 117 +++++++++++
 tb/tb_uart_tx_feeder.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_feeder.sv
// Byte FIFO plus handshake sequencer that feeds uart_tx one byte at a time.
// Optional dropped-write counter: define UART_TX_FEEDER_OVF_CNT_EN.
module uart_tx_feeder #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              i_Clock,
  input  logic              i_Reset,
  input  logic              i_Wr_DV,
  input  logic [7:0]        i_Wr_Byte,
  output logic              o_Full,
  output logic              o_Empty,
  output logic [ADDR_W:0]   o_Count,
  output logic              o_Tx_DV,
  output logic [7:0]        o_Tx_Byte,
  input  logic              i_Tx_Active,
  input  logic              i_Tx_Done,
`ifdef UART_TX_FEEDER_OVF_CNT_EN
  output logic [7:0]        o_Ovf_Count,
  input  logic              i_Ovf_Clr,
`endif
  output logic              o_Busy
);

  typedef enum logic [1:0] {s_IDLE, s_WAIT_DONE, s_GAP} state_t;

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] ONE_C   = (ADDR_W+1)'(1);

  state_t              state_q;
  logic [7:0]          mem_q [DEPTH];
  logic [ADDR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0]     count_q, count_d;
  logic                full, empty, pop, wr_acc;

  assign full    = (count_q == DEPTH_C);
  assign empty   = (count_q == '0);
  assign o_Full  = full;
  assign o_Empty = empty;
  assign o_Count = count_q;

  // Active guard also covers a frame still running after a reset of this block.
  assign pop    = (state_q == s_IDLE) && !empty && !i_Tx_Active;
  assign wr_acc = i_Wr_DV && (!full || pop);

  always_comb begin
    rd_ptr_d = rd_ptr_q + ADDR_W'(pop);
    wr_ptr_d = wr_ptr_q + ADDR_W'(wr_acc);
    count_d  = count_q;
    case ({wr_acc, pop})
      2'b10:   count_d = count_q + ONE_C;
      2'b01:   count_d = count_q - ONE_C;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge i_Clock) begin
    if (wr_acc) mem_q[wr_ptr_q] <= i_Wr_Byte;
  end

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      state_q   <= s_IDLE;
      o_Tx_DV   <= 1'b0;
      o_Tx_Byte <= 8'h00;
      o_Busy    <= 1'b0;
    end else begin
      o_Tx_DV <= 1'b0;
      case (state_q)
        s_IDLE: begin
          if (pop) begin
            o_Tx_Byte <= mem_q[rd_ptr_q];
            o_Tx_DV   <= 1'b1;
            o_Busy    <= 1'b1;
            state_q   <= s_WAIT_DONE;
          end
        end
        s_WAIT_DONE: begin
          if (i_Tx_Done) begin
            o_Busy  <= 1'b0;
            state_q <= s_GAP;
          end
        end
        // Let uart_tx pass its cleanup state before the next pop.
        s_GAP: begin
          o_Busy  <= 1'b0;
          state_q <= s_IDLE;
        end
        default: state_q <= s_IDLE;
      endcase
    end
  end

`ifdef UART_TX_FEEDER_OVF_CNT_EN
  logic [7:0] ovf_q;
  assign o_Ovf_Count = ovf_q;

  always_ff @(posedge i_Clock) begin
    if (i_Reset || i_Ovf_Clr) ovf_q <= 8'h00;
    else if (i_Wr_DV && !wr_acc && (ovf_q != 8'hFF)) ovf_q <= ovf_q + 8'h01;
  end
`endif

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Directed bench for uart_tx_feeder with a behavioural uart_tx and a byte scoreboard.
module tb_uart_tx_feeder;
  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;
  localparam int CPB    = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              wr_dv = 1'b0;
  logic [7:0]        wr_byte = 8'h00;
  logic              full, empty, tx_dv, busy;
  logic [ADDR_W:0]   count;
  logic [7:0]        tx_byte;
  logic              tx_active, tx_done;
  logic              hold_busy = 1'b0;
  logic              stray_done = 1'b0;
`ifdef UART_TX_FEEDER_OVF_CNT_EN
  logic [7:0]        ovf_cnt;
  logic              ovf_clr = 1'b0;
`endif

  int errors = 0;
  int checks = 0;
  int pulses = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  // Behavioural uart_tx: no reset, 10-bit frame, Done pulses as Active falls.
  logic       u_active = 1'b0;
  logic       u_done   = 1'b0;
  int         u_bit    = 0;
  int         u_cnt    = 0;
  always @(posedge clk) begin
    u_done <= 1'b0;
    if (!u_active) begin
      if (tx_dv === 1'b1) begin
        u_active <= 1'b1;
        u_bit    <= 0;
        u_cnt    <= 0;
      end
    end else if (u_cnt == CPB-1) begin
      u_cnt <= 0;
      if (u_bit == 9) begin
        u_active <= 1'b0;
        u_done   <= 1'b1;
      end else u_bit <= u_bit + 1;
    end else u_cnt <= u_cnt + 1;
  end

  assign tx_active = u_active | hold_busy;
  assign tx_done   = u_done | stray_done;

  uart_tx_feeder #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .i_Clock(clk), .i_Reset(rst), .i_Wr_DV(wr_dv), .i_Wr_Byte(wr_byte),
    .o_Full(full), .o_Empty(empty), .o_Count(count),
    .o_Tx_DV(tx_dv), .o_Tx_Byte(tx_byte),
    .i_Tx_Active(tx_active), .i_Tx_Done(tx_done),
`ifdef UART_TX_FEEDER_OVF_CNT_EN
    .o_Ovf_Count(ovf_cnt), .i_Ovf_Clr(ovf_clr),
`endif
    .o_Busy(busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (!(exp_q.size() == 0 && !busy && empty && !u_active) && n < 4000) begin
      tick();
      n++;
    end
    chk({"drain_", tag}, 32'(n < 4000), 1);
    tick();
    tick();
  endtask

  // Scoreboard side: every start pulse must match the oldest queued byte.
  logic prev_dv = 1'b0;
  always @(negedge clk) begin
    if (rst) prev_dv = 1'b0;
    else begin
      if (tx_dv === 1'b1) begin
        pulses++;
        chk("dv_while_active", 32'(tx_active), 0);
        chk("dv_one_cycle", 32'(prev_dv), 0);
        chk("pulse_expected", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) chk("tx_byte_order", 32'(tx_byte), 32'(exp_q.pop_front()));
      end
      prev_dv = tx_dv;
    end
  end

  initial begin
    int n;
    int base;
    logic [2:0] burst_cnt [5];
    burst_cnt[0] = 3'd1; burst_cnt[1] = 3'd1; burst_cnt[2] = 3'd2;
    burst_cnt[3] = 3'd3; burst_cnt[4] = 3'd4;

    // Reset state
    tick(); tick();
    chk("rst_tx_dv", 32'(tx_dv), 0);
    chk("rst_tx_byte", 32'(tx_byte), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_full", 32'(full), 0);
    chk("rst_empty", 32'(empty), 1);
    chk("rst_count", 32'(count), 0);
`ifdef UART_TX_FEEDER_OVF_CNT_EN
    chk("rst_ovf", 32'(ovf_cnt), 0);
`endif
    rst = 1'b0;
    tick();

    // Single byte: latency, pulse width, busy release
    wr_dv = 1'b1; wr_byte = 8'hA5; exp_q.push_back(8'hA5);
    tick();
    wr_dv = 1'b0;
    chk("single_empty", 32'(empty), 0);
    chk("single_count", 32'(count), 1);
    chk("single_dv_early", 32'(tx_dv), 0);
    tick();
    chk("single_dv", 32'(tx_dv), 1);
    chk("single_byte", 32'(tx_byte), 32'hA5);
    chk("single_busy", 32'(busy), 1);
    tick();
    chk("single_dv_fall", 32'(tx_dv), 0);
    chk("single_byte_hold", 32'(tx_byte), 32'hA5);
    n = 0;
    while (!tx_done && n < 200) begin tick(); n++; end
    chk("single_done_seen", 32'(tx_done), 1);
    chk("single_busy_at_done", 32'(busy), 1);
    tick();
    chk("single_busy_after_done", 32'(busy), 0);
    tick();
    chk("single_empty_end", 32'(empty), 1);
    tick();

    // Burst of five consecutive writes
    base = pulses;
    for (int i = 0; i < 5; i++) begin
      wr_dv = 1'b1; wr_byte = 8'(i + 1); exp_q.push_back(8'(i + 1));
      tick();
      chk("burst_count", 32'(count), 32'(burst_cnt[i]));
    end
    wr_dv = 1'b0;
    wait_idle("burst");
    chk("burst_pulses", 32'(pulses - base), 5);
    chk("burst_empty", 32'(empty), 1);

    // Full and drop with the transmitter held busy
    base = pulses;
    hold_busy = 1'b1;
    for (int i = 0; i < DEPTH + 3; i++) begin
      wr_dv = 1'b1; wr_byte = 8'(8'h40 + i);
      if (i < DEPTH) exp_q.push_back(8'(8'h40 + i));
      tick();
    end
    wr_dv = 1'b0;
    chk("full_flag", 32'(full), 1);
    chk("full_count", 32'(count), DEPTH);
    chk("full_no_pulse", 32'(pulses - base), 0);
`ifdef UART_TX_FEEDER_OVF_CNT_EN
    chk("ovf_count", 32'(ovf_cnt), 3);
    wr_dv = 1'b1; wr_byte = 8'hEE; ovf_clr = 1'b1;
    tick();
    wr_dv = 1'b0; ovf_clr = 1'b0;
    chk("ovf_clr_wins", 32'(ovf_cnt), 0);
    chk("ovf_drop_count", 32'(count), DEPTH);
`endif
    hold_busy = 1'b0;
    wait_idle("full");
    chk("full_pulses", 32'(pulses - base), DEPTH);

    // Writes coinciding with pops keep the count steady
    base = pulses;
    hold_busy = 1'b1;
    wr_dv = 1'b1; wr_byte = 8'h90; exp_q.push_back(8'h90);
    tick();
    wr_dv = 1'b0;
    for (int k = 0; k < 3; k++) begin
      n = 0;
      while (busy && n < 400) begin tick(); n++; end
      tick(); tick();
      chk("simul_pre_count", 32'(count), 1);
      hold_busy = 1'b0;
      wr_dv = 1'b1; wr_byte = 8'(8'h91 + k); exp_q.push_back(8'(8'h91 + k));
      tick();
      wr_dv = 1'b0;
      chk("simul_count", 32'(count), 1);
      chk("simul_dv", 32'(tx_dv), 1);
      @(negedge clk);
      #1 hold_busy = 1'b1;
    end
    hold_busy = 1'b0;
    wait_idle("simul");
    chk("simul_pulses", 32'(pulses - base), 4);

    // Wrap-around: 40 bytes through the 16-entry FIFO
    base = pulses;
    for (int i = 0; i < 40; i++) begin
      wr_dv = 1'b1; wr_byte = 8'(i); exp_q.push_back(8'(i));
      tick();
      wr_dv = 1'b0;
      n = 0;
      while (count >= 12 && n < 2000) begin tick(); n++; end
    end
    wait_idle("wrap");
    chk("wrap_pulses", 32'(pulses - base), 40);

    // Reset in the middle of a frame with two bytes queued
    wr_dv = 1'b1; wr_byte = 8'h3C; exp_q.push_back(8'h3C);
    tick();
    wr_byte = 8'h11; exp_q.push_back(8'h11);
    tick();
    wr_byte = 8'h22; exp_q.push_back(8'h22);
    tick();
    wr_dv = 1'b0;
    n = 0;
    while (!(u_active && u_bit == 3) && n < 500) begin tick(); n++; end
    chk("midrst_in_data", 32'(n < 500), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_q.delete();
    chk("midrst_empty", 32'(empty), 1);
    chk("midrst_count", 32'(count), 0);
    chk("midrst_dv", 32'(tx_dv), 0);
    chk("midrst_busy", 32'(busy), 0);
    base = pulses;
    wr_dv = 1'b1; wr_byte = 8'h77; exp_q.push_back(8'h77);
    tick();
    wr_dv = 1'b0;
    n = 0;
    while (u_active && n < 500) begin
      chk("midrst_hold_dv", 32'(tx_dv), 0);
      tick();
      n++;
    end
    chk("midrst_old_done", 32'(tx_done), 1);
    chk("midrst_busy_at_done", 32'(busy), 0);
    tick();
    chk("midrst_dv_after", 32'(tx_dv), 1);
    chk("midrst_byte_after", 32'(tx_byte), 32'h77);
    wait_idle("midrst");
    chk("midrst_pulses", 32'(pulses - base), 1);

    // Stray Done while idle is ignored
    stray_done = 1'b1;
    tick();
    stray_done = 1'b0;
    tick();
    chk("stray_busy", 32'(busy), 0);
    chk("stray_dv", 32'(tx_dv), 0);
    chk("stray_empty", 32'(empty), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    errors++;
    $display("FAIL timeout: simulation did not complete");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "timeout");
  end
endmodule
